// File: rtl/rf_pkg.sv
// Shared defaults and types for the integer register file and its scoreboard.
package rf_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_ZERO      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0]          xlen_t;

endpackage

// File: rtl/rf_busy_vec.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush/reset clear all.
module rf_busy_vec
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // A same-cycle set beats the clear: the newly issued producer owns the register.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (set_en && set_idx == AW'(r)) begin
                w_busy_nxt[r] = 1'b1;
            end else if (clr_en && clr_idx == AW'(r)) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with combinational read ports, writeback bypass and busy scoreboard.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_wb_en;
    logic             w_iss_en;

    assign w_wb_en  = wb_valid  && (wb_rd  != AW'(REG_ZERO));
    assign w_iss_en = iss_valid && (iss_rd != AW'(REG_ZERO));

    // Entry 0 is cleared by reset and never written, so it always holds zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_mem[r] <= '0;
            end
        end else if (w_wb_en) begin
            r_mem[wb_rd] <= wb_data;
        end
    end

    rf_busy_vec #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk     (clk),
        .rst     (rst),
        .set_en  (w_iss_en),
        .set_idx (iss_rd),
        .clr_en  (w_wb_en),
        .clr_idx (wb_rd),
        .flush   (flush),
        .busy    (w_busy)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_zero;
        logic            w_hit;
        logic [XLEN-1:0] w_data;

        assign w_ra   = ra[i*AW +: AW];
        assign w_zero = rst || (w_ra == AW'(REG_ZERO));
        assign w_hit  = wb_valid && (wb_rd == w_ra);
        assign w_data = w_zero ? '0 : (w_hit ? wb_data : r_mem[w_ra]);

        assign rd_data[i*XLEN +: XLEN] = w_data;
        assign rd_busy[i]              = !w_zero && !w_hit && w_busy[w_ra];
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined core, with NREAD combinational read ports, one writeback port and a per-register busy scoreboard. Decode issues a destination register and its busy bit is set; writeback writes the data and clears the busy bit. Write-to-read bypass removes the same-cycle writeback hazard. Sits between decode (reads, issue) and the writeback stage; hazard logic consumes the busy flags.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, at least 2); register 0 is hardwired zero
NREAD, 2, number of read ports (1 to 4)
AW (localparam), clog2(NREGS), register address width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
ra  input  NREAD*AW  read addresses; port i uses bits [i*AW +: AW]
rd_data  output  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rd_busy  output  NREAD  port i register has a pending producer
iss_valid  input  1  decode issues an instruction that writes iss_rd
iss_rd  input  AW  destination register of the issued instruction
wb_valid  input  1  writeback valid
wb_rd  input  AW  writeback destination
wb_data  input  XLEN  writeback data
flush  input  1  pipeline flush; clears all busy bits

Behaviour:
- Storage: NREGS x XLEN array plus an NREGS-bit busy vector. Entry 0 always reads 0 and is never busy; writes and issues to register 0 are ignored.
- Reset (rst=1 at a clk edge): all registers become 0 and all busy bits become 0. While rst=1, every rd_data is 0 and every rd_busy is 0, combinationally. An issue or writeback in a reset cycle is discarded.
- Write: if wb_valid and wb_rd != 0, then mem[wb_rd] <= wb_data on the rising edge. A write to a non-busy register is legal and performed.
- Read, combinational with zero latency, for each port i:
  - ra_i == 0: rd_data = 0, rd_busy = 0.
  - else if wb_valid and wb_rd == ra_i: rd_data = wb_data (bypass), rd_busy = 0.
  - else: rd_data = mem[ra_i], rd_busy = busy[ra_i].
  - An issue in the current cycle never affects current-cycle reads.
- Busy update on the rising edge, when rst=0:
  - flush=1: busy <= all zeros. A concurrent iss_valid is ignored. A concurrent writeback data write still occurs.
  - else, for each r != 0: set if iss_valid and iss_rd == r; otherwise clear if wb_valid and wb_rd == r; otherwise hold.
  - Issue and writeback to the same register in the same cycle leave the bit set, because the new producer wins.
- Repeated issue to an already-busy register keeps it busy. There is no producer counting; the first matching writeback clears the bit.
- Several read ports may address the same register and return identical results.
- No other state and no handshakes. All outputs depend only on the current inputs and the stored state.

Decomposition:
- Shared package rf_pkg: XLEN_DEFAULT = 32, NREGS_DEFAULT = 32, REG_ZERO = 0, and the typedefs reg_addr_t and xlen_t.
- Sub-module rf_busy_vec: the NREGS-bit scoreboard with inputs set_en/set_idx, clr_en/clr_idx, flush and rst, and output busy[NREGS-1:0]. It is instantiated once. Storage and the read/bypass muxes stay in the top level. The read mux is generated per port with a for-generate loop.

Test Plan:
- Reset and zero: set rst=1 for 1 cycle, then read ra={5,31} -> rd_data=0, rd_busy=0. Write wb_rd=0, wb_data=0xDEADBEEF, then read ra=0 -> rd_data=0.
- Write then read: wb_valid, wb_rd=3, wb_data=0x12345678. In the same cycle read ra0=3 -> 0x12345678 via bypass, rd_busy=0. In the next cycle with wb_valid=0 -> 0x12345678 from the array.
- Scoreboard lifecycle: issue iss_rd=7. Next cycle ra1=7 -> rd_busy=1. Writeback wb_rd=7, data=0xA5A5A5A5 -> rd_busy=0 in the same cycle and the data is bypassed. In the following cycle busy[7]=0.
- Simultaneous: iss_rd=9 and wb_rd=9 in the same cycle -> next cycle rd_busy for 9 is 1 and rd_data equals the written value. Issue to 9 and writeback to 10 in the same cycle -> 9 busy, 10 not busy.
- Flush: issue registers 4, 5 and 6 in three consecutive cycles. Assert flush together with iss_rd=8 -> next cycle busy is 0 for 4, 5, 6 and 8.
- Reset mid-operation: with registers 2 and 3 busy and non-zero, assert rst together with wb_valid to register 2 -> next cycle all rd_data=0 and rd_busy=0. Repeat the test with NREAD=3 and XLEN=64 to check the parameter generalisation.
